// File: rtl/sys_defs.sv
// Shared types and constants for the reorder buffer and its neighbours.
package sys_defs;

  localparam int unsigned ROB_DEPTH_DEFAULT = 8;
  localparam logic [4:0]  ZERO_REG          = 5'd0;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [31:0] value;
    logic [31:0] dest_addr;
    logic [4:0]  dest_reg;
    logic        wr_mem;
    MEM_SIZE     mem_size;
  } ROB_ENTRY;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and commit-side signals of the reorder buffer.
interface reorder_buffer_if
  import sys_defs::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
);

  logic             disp_valid;
  logic [4:0]       disp_dest_reg;
  logic             disp_wr_mem;
  MEM_SIZE          disp_mem_size;
  logic             disp_ready;
  logic [TAG_W-1:0] disp_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic [31:0]      cdb_addr;

  logic             mem_busy;
  ROB_ENTRY         head_entry;
  logic             head_ready;
  logic [TAG_W:0]   rob_count;

  modport master (
    output disp_valid, disp_dest_reg, disp_wr_mem, disp_mem_size,
    output cdb_valid, cdb_tag, cdb_value, cdb_addr, mem_busy,
    input  disp_ready, disp_tag, head_entry, head_ready, rob_count
  );

  modport slave (
    input  disp_valid, disp_dest_reg, disp_wr_mem, disp_mem_size,
    input  cdb_valid, cdb_tag, cdb_value, cdb_addr, mem_busy,
    output disp_ready, disp_tag, head_entry, head_ready, rob_count
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer; head retires in the cycle head_ready is high.
// Define ROB_FLUSH_EN to add the flush input that empties the buffer.
module reorder_buffer
  import sys_defs::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT,
  parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input logic             clock,
  input logic             reset,
`ifdef ROB_FLUSH_EN
  input logic             flush,
`endif
  reorder_buffer_if.slave rob
);

  localparam int unsigned PTR_W = TAG_W + 1;

  ROB_ENTRY         r_entries     [ROB_DEPTH];
  ROB_ENTRY         w_entries_nxt [ROB_DEPTH];
  logic [TAG_W:0]   r_head;
  logic [TAG_W:0]   r_tail;
  logic [TAG_W:0]   w_head_nxt;
  logic [TAG_W:0]   w_tail_nxt;
  logic [TAG_W-1:0] w_head_idx;
  logic [TAG_W-1:0] w_tail_idx;
  ROB_ENTRY         w_head_entry;
  logic             w_full;
  logic             w_head_ready;
  logic             w_dispatch;

  assign w_head_idx   = r_head[TAG_W-1:0];
  assign w_tail_idx   = r_tail[TAG_W-1:0];
  assign w_head_entry = r_entries[w_head_idx];
  assign w_full       = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
  // A stalled store at the head is released as soon as mem_busy drops.
  assign w_head_ready = w_head_entry.valid && w_head_entry.done &&
                        !(w_head_entry.wr_mem && rob.mem_busy);
  assign w_dispatch   = rob.disp_valid && !w_full;

  assign rob.disp_ready = !w_full;
  assign rob.disp_tag   = w_tail_idx;
  assign rob.head_entry = w_head_entry;
  assign rob.head_ready = w_head_ready;
  assign rob.rob_count  = r_tail - r_head;

  // Next-state of entries and pointers: completion, then retire, then dispatch.
  always_comb begin
    w_entries_nxt = r_entries;
    w_head_nxt    = r_head;
    w_tail_nxt    = r_tail;

    if (rob.cdb_valid && r_entries[rob.cdb_tag].valid) begin
      w_entries_nxt[rob.cdb_tag].done  = 1'b1;
      w_entries_nxt[rob.cdb_tag].value = rob.cdb_value;
      if (r_entries[rob.cdb_tag].wr_mem) begin
        w_entries_nxt[rob.cdb_tag].dest_addr = rob.cdb_addr;
      end
    end

    if (w_head_ready) begin
      w_entries_nxt[w_head_idx].valid = 1'b0;
      w_head_nxt                      = r_head + PTR_W'(1);
    end

    if (w_dispatch) begin
      w_entries_nxt[w_tail_idx].valid     = 1'b1;
      w_entries_nxt[w_tail_idx].done      = 1'b0;
      w_entries_nxt[w_tail_idx].value     = 32'd0;
      w_entries_nxt[w_tail_idx].dest_addr = 32'd0;
      w_entries_nxt[w_tail_idx].dest_reg  = rob.disp_dest_reg;
      w_entries_nxt[w_tail_idx].wr_mem    = rob.disp_wr_mem;
      w_entries_nxt[w_tail_idx].mem_size  = rob.disp_mem_size;
      w_tail_nxt                          = r_tail + PTR_W'(1);
    end

`ifdef ROB_FLUSH_EN
    if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        w_entries_nxt[i].valid = 1'b0;
        w_entries_nxt[i].done  = 1'b0;
      end
      w_head_nxt = '0;
      w_tail_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_entries <= '{default: '0};
      r_head    <= '0;
      r_tail    <= '0;
    end else begin
      r_entries <= w_entries_nxt;
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
    end
  end

endmodule
